matrix_multiply_param: RTL
==========================

MATRIX_MULTIPLY_PARAM -- requirements
Module: matrix_multiply_param

Interface
REQ-001 Parameter DATA_W, default 8: element width; also the width of stored results.
REQ-002 Parameter ACC_W, default 16: accumulator width; SHALL be at least DATA_W.
REQ-003 Parameter N_MAX, default 8: largest accepted matrix dimension.
REQ-004 Parameter ADDR_W, default 10: memory address width.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 go  in  1  start request, sampled in IDLE and DONE.
REQ-008 n_in  in  $clog2(N_MAX+1)  dimension N, captured when go is accepted.
REQ-009 base_a  in  ADDR_W  base of A, captured with go; B at base_a+N*N, R at base_a+2*N*N (row-major).
REQ-010 b_transpose  in  1  captured with go; 1 = B stored column-major.
REQ-011 mem_addr  out  ADDR_W  registered memory address.
REQ-012 mem_wdata  out  DATA_W  registered write data.
REQ-013 mem_we  out  1  registered write enable.
REQ-014 mem_rdata  in  DATA_W  read data, valid one cycle after the cycle in which the memory samples mem_addr.
REQ-015 data_out  out  DATA_W  last result written.
REQ-016 data_rdy  out  1  high while in DONE.
REQ-017 busy  out  1  high in every state except IDLE and DONE.
REQ-018 err  out  1  high in DONE when n_in was 0 or greater than N_MAX.

Function
REQ-019 States: IDLE, SETUP, ROW, COL, KLOOP, RD_A, WAIT_A, RD_B, WAIT_B, MAC, STORE, DONE; each state lasts exactly one cycle except IDLE and DONE.
REQ-020 IDLE or DONE with go=1 -> SETUP; capture n_in, base_a and b_transpose; clear r, err and data_rdy.
REQ-021 SETUP: compute the B and R bases; if N=0 or N>N_MAX set err=1 and go to DONE, otherwise go to ROW.
REQ-022 ROW: if r<N, set c=0 and go to COL; otherwise go to DONE.
REQ-023 COL: if c<N, set acc=0 and k=0 and go to KLOOP; otherwise increment r and go to ROW.
REQ-024 KLOOP: if k<N go to RD_A; otherwise go to STORE.
REQ-025 RD_A: mem_addr = A + r*N + k, mem_we = 0.
REQ-026 WAIT_A: no action.
REQ-027 RD_B: capture mem_rdata as word_a; mem_addr = B + k*N + c, or B + c*N + k when b_transpose = 1.
REQ-028 WAIT_B: no action.
REQ-029 MAC: acc += word_a * mem_rdata, computed at ACC_W width; increment k; go to KLOOP.
REQ-030 STORE: mem_addr = R + r*N + c; mem_wdata = result; mem_we = 1 for exactly this cycle; data_out = result; increment c; go to COL.
REQ-031 result is acc[DATA_W-1:0], subject to REQ-037.
REQ-032 Total latency: data_rdy rises 1 + (N+1) + N(N+1) + N^2(6N+2) cycles after the clock edge that accepts go; for N=3 this is 197 cycles.
REQ-033 go while busy=1 is ignored.
REQ-034 The block never reads and writes memory in the same cycle.

Reset
REQ-035 reset_n low asynchronously forces IDLE at any point, including mid-operation; the interrupted matrix is not completed.
REQ-036 Reset values: mem_we = 0, mem_addr = 0, mem_wdata = 0, data_out = 0, data_rdy = 0, busy = 0, err = 0, acc = 0.

Configuration
REQ-037 Macro MATRIX_MULTIPLY_SATURATE_EN:
- Defined: acc saturates at 2^ACC_W-1 instead of wrapping; result = min(acc, 2^DATA_W-1).
- Undefined: acc wraps modulo 2^ACC_W; result is truncated to DATA_W bits.

Verification
REQ-038 A = B = [0..8] row-major at base_a=0, N=3, b_transpose=0 -> mem[18..26] = 15,18,21,42,54,66,69,90,111; data_rdy rises 197 cycles after go.
REQ-039 Same stimulus with b_transpose=1 (B data unchanged) -> mem[18..26] = 5,14,23,14,50,86,23,86,149.
REQ-040 N=2, all elements of A and B = 16 -> all four results are 0 without the macro and 255 with MATRIX_MULTIPLY_SATURATE_EN.
REQ-041 go with n_in=0, and separately with n_in=N_MAX+1 -> DONE after 2 cycles with err=1 and no mem_we pulse.
REQ-042 reset_n pulsed low during MAC of the second element -> immediately IDLE, mem_we=0, busy=0; a new go reruns REQ-038 correctly.
REQ-043 go held high throughout an operation -> the run is unaffected; a restart from DONE clears data_rdy on the next cycle.

Source files
------------

// File: rtl/matrix_multiply_param_if.sv
// Memory port of matrix_multiply_param: one synchronous single-port RAM, read data one cycle after address.
interface matrix_multiply_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/matrix_multiply_param.sv
// Sequential NxN matrix multiply R = A*B out of one shared memory, one MAC per 6 cycles.
// Optional macro MATRIX_MULTIPLY_SATURATE_EN: saturating accumulator/result instead of wrap/truncate.
module matrix_multiply_param #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int N_MAX  = 8,
  parameter int ADDR_W = 10
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         go,
  input  logic [$clog2(N_MAX+1)-1:0]   n_in,
  input  logic [ADDR_W-1:0]            base_a,
  input  logic                         b_transpose,
  matrix_multiply_param_if.master      mem,
  output logic [DATA_W-1:0]            data_out,
  output logic                         data_rdy,
  output logic                         busy,
  output logic                         err
);
  localparam int NW = $clog2(N_MAX+1);
  localparam int PW = 2*DATA_W;

  typedef enum logic [3:0] {
    IDLE, SETUP, ROW, COL, KLOOP, RD_A, WAIT_A, RD_B, WAIT_B, MAC, STORE, DONE
  } state_t;

  state_t            state;
  logic [NW-1:0]     n, r, c, k;
  logic [ADDR_W-1:0] a_base, b_base, r_base;
  logic              bt;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] word_a;

  logic [ADDR_W-1:0] nn, row_off;
  logic [PW-1:0]     prod;
  logic [ACC_W-1:0]  acc_next;
  logic [DATA_W-1:0] result;

  assign nn      = ADDR_W'(n) * ADDR_W'(n);
  assign row_off = ADDR_W'(r) * ADDR_W'(n);
  assign prod    = word_a * mem.mem_rdata;

`ifdef MATRIX_MULTIPLY_SATURATE_EN
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
  logic [SW-1:0] sum_w;
  assign sum_w    = SW'(acc) + SW'(prod);
  assign acc_next = (sum_w > SW'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
  assign result   = (acc > ACC_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
`else
  assign acc_next = acc + ACC_W'(prod);
  assign result   = acc[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      n             <= '0;
      r             <= '0;
      c             <= '0;
      k             <= '0;
      a_base        <= '0;
      b_base        <= '0;
      r_base        <= '0;
      bt            <= 1'b0;
      acc           <= '0;
      word_a        <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_we    <= 1'b0;
      data_out      <= '0;
      data_rdy      <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      mem.mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // go is only looked at here, so it is ignored for the whole run
          if (go) begin
            state    <= SETUP;
            n        <= n_in;
            a_base   <= base_a;
            bt       <= b_transpose;
            r        <= '0;
            err      <= 1'b0;
            data_rdy <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          b_base <= a_base + nn;
          r_base <= a_base + nn + nn;
          if (n == '0 || n > NW'(N_MAX)) begin
            err      <= 1'b1;
            data_rdy <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            state <= ROW;
          end
        end
        ROW: begin
          if (r < n) begin
            c     <= '0;
            state <= COL;
          end else begin
            data_rdy <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        COL: begin
          if (c < n) begin
            acc   <= '0;
            k     <= '0;
            state <= KLOOP;
          end else begin
            r     <= r + NW'(1);
            state <= ROW;
          end
        end
        KLOOP: state <= (k < n) ? RD_A : STORE;
        RD_A: begin
          mem.mem_addr <= a_base + row_off + ADDR_W'(k);
          state        <= WAIT_A;
        end
        WAIT_A: state <= RD_B;
        RD_B: begin
          word_a <= mem.mem_rdata;
          if (bt)
            mem.mem_addr <= b_base + ADDR_W'(c) * ADDR_W'(n) + ADDR_W'(k);
          else
            mem.mem_addr <= b_base + ADDR_W'(k) * ADDR_W'(n) + ADDR_W'(c);
          state <= WAIT_B;
        end
        WAIT_B: state <= MAC;
        MAC: begin
          acc   <= acc_next;
          k     <= k + NW'(1);
          state <= KLOOP;
        end
        STORE: begin
          mem.mem_addr  <= r_base + row_off + ADDR_W'(c);
          mem.mem_wdata <= result;
          mem.mem_we    <= 1'b1;
          data_out      <= result;
          c             <= c + NW'(1);
          state         <= COL;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
